mio_bus_responder: RTL and testbench
====================================

// Module: mio_bus_responder
// PURPOSE
//  Memory/IO responder at the far end of the CPU data-bus handshake (cpu_mio, mem_w, addr, wdata -> rdata, mio_ready).
//  Decodes each request to on-chip data RAM (synchronous BRAM port) or to the peripheral window (req/ack port).
//  Inserts wait states and returns read data with a one-cycle mio_ready pulse per completed access.
//  Sits between the pipeline's MEM stage and the data RAM/IO fabric.
// PARAMETERS
//  RAM_AW      10          RAM word-address width (RAM = 2^RAM_AW 32-bit words)
//  RAM_WAIT    1           cycles from ram_en issue to valid ram_dout (>=1)
//  IO_TIMEOUT  16          cycles io_req may stay unacked before bus error (>=1)
//  IO_ERR_DATA 32'hDEAD_BEEF  rdata returned on IO timeout or misaligned access
// PORTS
//  clk         in   1   clock, rising edge
//  rst         in   1   asynchronous active-high reset
//  cpu_mio     in   1   request valid (level), sampled only in IDLE
//  mem_w       in   1   1=write, 0=read
//  addr        in   32  byte address; must be word aligned
//  wdata       in   32  write data
//  rdata       out  32  read data, valid when mio_ready=1, held until next response
//  mio_ready   out  1   one-cycle completion pulse
//  bus_err     out  1   one-cycle pulse coincident with mio_ready on error
//  ram_en      out  1   RAM enable
//  ram_we      out  1   RAM write enable
//  ram_addr    out  RAM_AW  word address = addr[RAM_AW+1:2]
//  ram_din     out  32  RAM write data
//  ram_dout    in   32  RAM read data
//  io_req      out  1   peripheral request, held until io_ack or timeout
//  io_we       out  1   peripheral write
//  io_addr     out  32  peripheral byte address
//  io_wdata    out  32  peripheral write data
//  io_rdata    in   32  peripheral read data, valid with io_ack
//  io_ack      in   1   peripheral completion
// BEHAVIOUR
//  - Reset (async): state=IDLE, all outputs 0, wait/timeout counters 0; an in-flight access is abandoned with no mio_ready.
//  - States: IDLE, RAM_ACC, IO_ACC, RESP.
//  - IDLE: if cpu_mio=1, latch addr/wdata/mem_w. Next state:
//    addr[1:0]!=0 -> RESP with bus_err, rdata=IO_ERR_DATA, no RAM/IO access.
//    addr[31:28]==4'hF -> IO_ACC. Otherwise -> RAM_ACC.
//  - RAM_ACC: ram_en=1, ram_we=latched mem_w, ram_addr/ram_din from latched values.
//    Stays RAM_WAIT cycles (counter); on the last cycle rdata<=ram_dout (reads) or 0 (writes); -> RESP.
//  - IO_ACC: io_req=1 with io_we/io_addr/io_wdata stable from the latch.
//    io_ack=1: rdata<=io_rdata (reads) or 0 (writes); -> RESP.
//    No ack after IO_TIMEOUT cycles in IO_ACC: rdata<=IO_ERR_DATA, bus_err set; -> RESP.
//    io_ack on the same cycle as timeout: ack wins, no error.
//  - RESP: mio_ready=1 (and bus_err if flagged) for exactly one cycle; ram_en/io_req=0; -> IDLE.
//  - Latency (request seen in IDLE at cycle 0): RAM mio_ready at cycle RAM_WAIT+1;
//    IO mio_ready at cycle (ack cycle)+1; misaligned at cycle 1.
//  - Back-to-back: cpu_mio still high in the IDLE cycle after RESP starts a new access. Max throughput is one access per RAM_WAIT+2 cycles.
//  - Requests/inputs outside IDLE are ignored; io_ack outside IO_ACC is ignored.
//  - rdata is registered and holds its last value; mio_ready and bus_err never assert outside RESP.
// TESTING
//  1. Write 0x0000_0010 <- 0x1234_5678, then read it back (RAM_WAIT=1): ram_we=1 with ram_addr=4;
//     read rdata=0x1234_5678, mio_ready exactly at cycle 2 of each access.
//  2. Read 0xF000_0004 with io_ack on the 3rd cycle of io_req and io_rdata=0xA5A5_0001:
//     rdata=0xA5A5_0001, mio_ready 1 cycle after ack, bus_err=0.
//  3. IO read with no ack (IO_TIMEOUT=16): io_req high 16 cycles, then mio_ready and bus_err pulse, rdata=0xDEAD_BEEF.
//  4. Read 0x0000_0006 (misaligned): no ram_en/io_req, mio_ready+bus_err at cycle 1, rdata=0xDEAD_BEEF.
//  5. Assert rst during IO_ACC: io_req drops immediately, no mio_ready;
//     after release a RAM read of 0x0000_0010 completes normally.
//  6. cpu_mio held high for 3 RAM reads: three mio_ready pulses spaced RAM_WAIT+2 cycles; ack+timeout same cycle -> no bus_err.

Source files
------------

// File: rtl/mio_bus_responder.sv
// mio_bus_responder
//   Far-end responder for the CPU data-bus handshake. Each request seen in
//   IDLE is decoded to the on-chip data RAM or to the peripheral window
//   (addr[31:28] == 4'hF). The responder holds the access for the needed
//   wait states, returns read data and pulses mio_ready for one cycle.
//   Misaligned requests complete at once with bus_err. Peripheral accesses
//   that get no io_ack within IO_TIMEOUT cycles also complete with bus_err.
//
// Ports
//   clk, rst           clock (rising edge), asynchronous active-high reset
//   cpu_mio            request valid (level), sampled only in IDLE
//   mem_w              1 = write, 0 = read
//   addr, wdata        byte address (word aligned) and write data
//   rdata              registered read data, holds until the next response
//   mio_ready          one-cycle completion pulse
//   bus_err            one-cycle error pulse, coincident with mio_ready
//   ram_en, ram_we     RAM enable / write enable
//   ram_addr, ram_din  RAM word address / write data
//   ram_dout           RAM read data
//   io_req, io_we      peripheral request / write (held until ack or timeout)
//   io_addr, io_wdata  peripheral byte address / write data
//   io_rdata, io_ack   peripheral read data / completion
module mio_bus_responder #(
  parameter int          RAM_AW      = 10,
  parameter int          RAM_WAIT    = 1,
  parameter int          IO_TIMEOUT  = 16,
  parameter logic [31:0] IO_ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_mio,
  input  logic              mem_w,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              mio_ready,
  output logic              bus_err,
  output logic              ram_en,
  output logic              ram_we,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [31:0]       ram_din,
  input  logic [31:0]       ram_dout,
  output logic              io_req,
  output logic              io_we,
  output logic [31:0]       io_addr,
  output logic [31:0]       io_wdata,
  input  logic [31:0]       io_rdata,
  input  logic              io_ack
);

  // One counter serves both the RAM wait states and the IO timeout, so it
  // is sized for the larger of the two terminal counts.
  localparam int CNT_MAX = (RAM_WAIT > IO_TIMEOUT) ? RAM_WAIT : IO_TIMEOUT;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] RAM_LAST = CNT_W'(RAM_WAIT - 1);
  localparam logic [CNT_W-1:0] IO_LAST  = CNT_W'(IO_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RAM_ACC = 2'd1,
    S_IO_ACC  = 2'd2,
    S_RESP    = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             we_q, we_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             mio_ready_q, mio_ready_d;
  logic             bus_err_q, bus_err_d;
  logic             ram_en_q, ram_en_d;
  logic             ram_we_q, ram_we_d;
  logic             io_req_q, io_req_d;
  logic             io_we_q, io_we_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    bus_err_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cpu_mio) begin
          we_d    = mem_w;
          addr_d  = addr;
          wdata_d = wdata;
          cnt_d   = '0;
          if (addr[1:0] != 2'b00) begin
            // Misaligned: answer immediately, never touch RAM or IO.
            state_d   = S_RESP;
            rdata_d   = IO_ERR_DATA;
            bus_err_d = 1'b1;
          end else if (addr[31:28] == 4'hF) begin
            state_d = S_IO_ACC;
          end else begin
            state_d = S_RAM_ACC;
          end
        end
      end

      S_RAM_ACC: begin
        if (cnt_q == RAM_LAST) begin
          rdata_d = we_q ? 32'h0 : ram_dout;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_IO_ACC: begin
        // An ack arriving in the final timeout cycle still completes cleanly.
        if (io_ack) begin
          rdata_d = we_q ? 32'h0 : io_rdata;
          state_d = S_RESP;
        end else if (cnt_q == IO_LAST) begin
          rdata_d   = IO_ERR_DATA;
          bus_err_d = 1'b1;
          state_d   = S_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_RESP: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Outputs are decoded from the next state so they are registered and
    // line up exactly with the state they belong to.
    mio_ready_d = (state_d == S_RESP);
    ram_en_d    = (state_d == S_RAM_ACC);
    ram_we_d    = ram_en_d & we_d;
    io_req_d    = (state_d == S_IO_ACC);
    io_we_d     = io_req_d & we_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      addr_q      <= 32'h0;
      wdata_q     <= 32'h0;
      rdata_q     <= 32'h0;
      mio_ready_q <= 1'b0;
      bus_err_q   <= 1'b0;
      ram_en_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      io_req_q    <= 1'b0;
      io_we_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      mio_ready_q <= mio_ready_d;
      bus_err_q   <= bus_err_d;
      ram_en_q    <= ram_en_d;
      ram_we_q    <= ram_we_d;
      io_req_q    <= io_req_d;
      io_we_q     <= io_we_d;
    end
  end

  assign rdata     = rdata_q;
  assign mio_ready = mio_ready_q;
  assign bus_err   = bus_err_q;
  assign ram_en    = ram_en_q;
  assign ram_we    = ram_we_q;
  assign ram_addr  = addr_q[RAM_AW+1:2];
  assign ram_din   = wdata_q;
  assign io_req    = io_req_q;
  assign io_we     = io_we_q;
  assign io_addr   = addr_q;
  assign io_wdata  = wdata_q;

endmodule

// File: tb/tb_mio_bus_responder.sv
// Testbench for mio_bus_responder: directed scenarios plus a randomized
// mix of RAM, IO, timeout and misaligned accesses checked against a
// transaction-level model of the responder.
module tb_mio_bus_responder;

  localparam int          RAM_AW   = 10;
  localparam int          RAM_WAIT = 1;
  localparam int          IO_TO    = 16;
  localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cpu_mio = 1'b0;
  logic              mem_w = 1'b0;
  logic [31:0]       addr = 32'h0;
  logic [31:0]       wdata = 32'h0;
  logic [31:0]       rdata;
  logic              mio_ready;
  logic              bus_err;
  logic              ram_en;
  logic              ram_we;
  logic [RAM_AW-1:0] ram_addr;
  logic [31:0]       ram_din;
  logic [31:0]       ram_dout;
  logic              io_req;
  logic              io_we;
  logic [31:0]       io_addr;
  logic [31:0]       io_wdata;
  logic [31:0]       io_rdata = 32'h0;
  logic              io_ack = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  mio_bus_responder #(
    .RAM_AW(RAM_AW), .RAM_WAIT(RAM_WAIT), .IO_TIMEOUT(IO_TO), .IO_ERR_DATA(ERR_DATA)
  ) dut (
    .clk(clk), .rst(rst), .cpu_mio(cpu_mio), .mem_w(mem_w), .addr(addr),
    .wdata(wdata), .rdata(rdata), .mio_ready(mio_ready), .bus_err(bus_err),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_dout(ram_dout), .io_req(io_req), .io_we(io_we), .io_addr(io_addr),
    .io_wdata(io_wdata), .io_rdata(io_rdata), .io_ack(io_ack)
  );

  always #5 clk = ~clk;

  // Data RAM attached to the responder: writes land on the clock edge,
  // read data is presented for the addressed word while enabled.
  logic [31:0] bram [0:(1<<RAM_AW)-1];
  initial for (int i = 0; i < (1 << RAM_AW); i++) bram[i] = 32'h0;
  always @(posedge clk) if (ram_en && ram_we) bram[ram_addr] <= ram_din;
  assign ram_dout = ram_en ? bram[ram_addr] : 32'h0;

  // Reference contents of the RAM, keyed by word index.
  logic [31:0] ref_mem [int];

  function automatic logic [31:0] ref_read(input int idx);
    return ref_mem.exists(idx) ? ref_mem[idx] : 32'h0;
  endfunction

  // Drives one access and reports what was observed. ack_at is the io_req
  // cycle (1-based) in which io_ack is raised; 0 means never.
  task automatic run_access(input logic w, input logic [31:0] a, input logic [31:0] d,
                            input int ack_at, input logic [31:0] iod,
                            output int lat, output logic [31:0] rd, output logic err,
                            output int ram_cyc, output int io_cyc, output int we_cyc,
                            output logic [RAM_AW-1:0] ra, output logic [31:0] ia);
    @(negedge clk);
    cpu_mio = 1'b1; mem_w = w; addr = a; wdata = d; io_ack = 1'b0;
    lat = -1; rd = 32'h0; err = 1'b0; ram_cyc = 0; io_cyc = 0; we_cyc = 0;
    ra = '0; ia = 32'h0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (ram_en) begin
        ram_cyc++; ra = ram_addr;
        if (ram_we) we_cyc++;
      end
      if (io_req) begin
        io_cyc++; ia = io_addr;
        if (io_we) we_cyc++;
        if (io_cyc == ack_at) begin
          io_ack = 1'b1; io_rdata = iod;
        end else begin
          io_ack = 1'b0; io_rdata = $urandom;
        end
      end else begin
        io_ack = 1'b0;
      end
      if (mio_ready) begin
        lat = c; rd = rdata; err = bus_err;
        break;
      end
    end
    cpu_mio = 1'b0; io_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({mio_ready, bus_err, ram_en, ram_we, io_req, io_we} !== 6'b0) begin
      n_bad++;
      $display("FAIL reset_ctrl: got %b want 000000",
               {mio_ready, bus_err, ram_en, ram_we, io_req, io_we});
    end
    n_cmp++;
    if ({rdata, io_addr, io_wdata, ram_din, ram_addr} !== '0) begin
      n_bad++;
      $display("FAIL reset_data: rdata=%h io_addr=%h io_wdata=%h ram_din=%h ram_addr=%h want all 0",
               rdata, io_addr, io_wdata, ram_din, ram_addr);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_ram_rw();
    int lat, rc, ic, wc; logic [31:0] rd, ia; logic err; logic [RAM_AW-1:0] ra;
    run_access(1'b1, 32'h0000_0010, 32'h1234_5678, 0, 32'h0, lat, rd, err, rc, ic, wc, ra, ia);
    ref_mem[4] = 32'h1234_5678;
    n_cmp++;
    if (lat !== RAM_WAIT + 1) begin n_bad++; $display("FAIL ram_wr_latency: got %0d want %0d", lat, RAM_WAIT + 1); end
    n_cmp++;
    if (ra !== 10'd4 || wc !== RAM_WAIT || rc !== RAM_WAIT || ic !== 0) begin
      n_bad++; $display("FAIL ram_wr_port: ram_addr=%0d we_cyc=%0d en_cyc=%0d io_cyc=%0d want 4/%0d/%0d/0", ra, wc, rc, ic, RAM_WAIT, RAM_WAIT);
    end
    n_cmp++;
    if (rd !== 32'h0 || err !== 1'b0) begin n_bad++; $display("FAIL ram_wr_resp: rdata=%h err=%b want 0/0", rd, err); end
    run_access(1'b0, 32'h0000_0010, 32'h0, 0, 32'h0, lat, rd, err, rc, ic, wc, ra, ia);
    n_cmp++;
    if (lat !== RAM_WAIT + 1) begin n_bad++; $display("FAIL ram_rd_latency: got %0d want %0d", lat, RAM_WAIT + 1); end
    n_cmp++;
    if (rd !== 32'h1234_5678 || err !== 1'b0 || wc !== 0) begin
      n_bad++; $display("FAIL ram_rd_data: rdata=%h err=%b we_cyc=%0d want 12345678/0/0", rd, err, wc);
    end
  endtask

  task automatic test_io_read();
    int lat, rc, ic, wc; logic [31:0] rd, ia; logic err; logic [RAM_AW-1:0] ra;
    run_access(1'b0, 32'hF000_0004, 32'h0, 3, 32'hA5A5_0001, lat, rd, err, rc, ic, wc, ra, ia);
    n_cmp++;
    if (lat !== 4) begin n_bad++; $display("FAIL io_rd_latency: got %0d want 4", lat); end
    n_cmp++;
    if (rd !== 32'hA5A5_0001 || err !== 1'b0) begin n_bad++; $display("FAIL io_rd_data: rdata=%h err=%b want a5a50001/0", rd, err); end
    n_cmp++;
    if (ia !== 32'hF000_0004 || rc !== 0 || ic !== 3) begin
      n_bad++; $display("FAIL io_rd_port: io_addr=%h ram_cyc=%0d io_cyc=%0d want f0000004/0/3", ia, rc, ic);
    end
  endtask

  task automatic test_io_timeout();
    int lat, rc, ic, wc; logic [31:0] rd, ia; logic err; logic [RAM_AW-1:0] ra;
    run_access(1'b0, 32'hF000_0008, 32'h0, 0, 32'h0, lat, rd, err, rc, ic, wc, ra, ia);
    n_cmp++;
    if (ic !== IO_TO || lat !== IO_TO + 1) begin n_bad++; $display("FAIL io_timeout_len: io_cyc=%0d lat=%0d want %0d/%0d", ic, lat, IO_TO, IO_TO + 1); end
    n_cmp++;
    if (rd !== ERR_DATA || err !== 1'b1) begin n_bad++; $display("FAIL io_timeout_resp: rdata=%h err=%b want deadbeef/1", rd, err); end
    // Ack in the very cycle the timeout would expire: ack takes priority.
    run_access(1'b0, 32'hF000_000C, 32'h0, IO_TO, 32'h5555_AAAA, lat, rd, err, rc, ic, wc, ra, ia);
    n_cmp++;
    if (lat !== IO_TO + 1 || rd !== 32'h5555_AAAA || err !== 1'b0) begin
      n_bad++; $display("FAIL io_ack_at_timeout: lat=%0d rdata=%h err=%b want %0d/5555aaaa/0", lat, rd, err, IO_TO + 1);
    end
  endtask

  task automatic test_misaligned();
    int lat, rc, ic, wc; logic [31:0] rd, ia; logic err; logic [RAM_AW-1:0] ra;
    run_access(1'b0, 32'h0000_0006, 32'h0, 0, 32'h0, lat, rd, err, rc, ic, wc, ra, ia);
    n_cmp++;
    if (lat !== 1 || rc !== 0 || ic !== 0) begin n_bad++; $display("FAIL misaligned_access: lat=%0d ram_cyc=%0d io_cyc=%0d want 1/0/0", lat, rc, ic); end
    n_cmp++;
    if (rd !== ERR_DATA || err !== 1'b1) begin n_bad++; $display("FAIL misaligned_resp: rdata=%h err=%b want deadbeef/1", rd, err); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if (mio_ready !== 1'b0 || bus_err !== 1'b0 || rdata !== ERR_DATA) begin
        n_bad++; $display("FAIL rdata_hold: ready=%b err=%b rdata=%h want 0/0/deadbeef", mio_ready, bus_err, rdata);
      end
    end
  endtask

  task automatic test_reset_during_io();
    int lat, rc, ic, wc; logic [31:0] rd, ia; logic err; logic [RAM_AW-1:0] ra;
    int spurious;
    @(negedge clk);
    cpu_mio = 1'b1; mem_w = 1'b0; addr = 32'hF000_0010; io_ack = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (io_req !== 1'b1) begin n_bad++; $display("FAIL rst_io_pre: io_req=%b want 1", io_req); end
    rst = 1'b1;
    #1;
    n_cmp++;
    if (io_req !== 1'b0 || mio_ready !== 1'b0) begin n_bad++; $display("FAIL rst_io_drop: io_req=%b ready=%b want 0/0", io_req, mio_ready); end
    cpu_mio = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    spurious = 0;
    repeat (5) begin
      @(negedge clk);
      if (mio_ready || io_req || ram_en) spurious++;
    end
    n_cmp++;
    if (spurious !== 0) begin n_bad++; $display("FAIL rst_io_quiet: active cycles=%0d want 0", spurious); end
    run_access(1'b0, 32'h0000_0010, 32'h0, 0, 32'h0, lat, rd, err, rc, ic, wc, ra, ia);
    n_cmp++;
    if (lat !== RAM_WAIT + 1 || rd !== ref_read(4) || err !== 1'b0) begin
      n_bad++; $display("FAIL rst_then_ram: lat=%0d rdata=%h err=%b want %0d/%h/0", lat, rd, err, RAM_WAIT + 1, ref_read(4));
    end
  endtask

  task automatic test_back_to_back();
    int pulses [$];
    int errs, extra;
    @(negedge clk);
    cpu_mio = 1'b1; mem_w = 1'b0; addr = 32'h0000_0010;
    io_ack = 1'b1;  // outside IO_ACC this must have no effect
    errs = 0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (mio_ready) begin
        pulses.push_back(c);
        if (bus_err || rdata !== ref_read(4)) errs++;
        if (pulses.size() == 3) begin cpu_mio = 1'b0; break; end
      end
    end
    cpu_mio = 1'b0;
    extra = 0;
    repeat (4) begin
      @(negedge clk);
      if (mio_ready) extra++;
    end
    io_ack = 1'b0;
    n_cmp++;
    if (pulses.size() !== 3 || extra !== 0) begin
      n_bad++; $display("FAIL b2b_count: pulses=%0d extra=%0d want 3/0", pulses.size(), extra);
    end else begin
      for (int k = 0; k < 3; k++) begin
        n_cmp++;
        if (pulses[k] !== RAM_WAIT + 1 + k * (RAM_WAIT + 2)) begin
          n_bad++; $display("FAIL b2b_spacing: pulse %0d at cycle %0d want %0d", k, pulses[k], RAM_WAIT + 1 + k * (RAM_WAIT + 2));
        end
      end
    end
    n_cmp++;
    if (errs !== 0) begin n_bad++; $display("FAIL b2b_data: bad responses=%0d want 0", errs); end
  endtask

  task automatic test_random();
    int lat, rc, ic, wc, kind, k, idx, exp_lat, exp_ic;
    logic [31:0] rd, ia, a, d, iod, exp_rd, last_rd;
    logic err, w, exp_err;
    logic [RAM_AW-1:0] ra;
    last_rd = rdata;
    for (int it = 0; it < 60; it++) begin
      kind = $urandom_range(0, 3);
      w = 1'($urandom_range(0, 1));
      d = $urandom;
      if (kind == 0) begin
        idx = $urandom_range(0, 15);
        a = {4'($urandom_range(0, 14)), 16'($urandom), 10'(idx), 2'b00};
        run_access(w, a, d, 0, 32'h0, lat, rd, err, rc, ic, wc, ra, ia);
        exp_rd = w ? 32'h0 : ref_read(idx);
        if (w) ref_mem[idx] = d;
        n_cmp++;
        if (lat !== RAM_WAIT + 1 || rd !== exp_rd || err !== 1'b0) begin
          n_bad++; $display("FAIL rnd_ram: it=%0d w=%b a=%h lat=%0d rdata=%h err=%b want %0d/%h/0", it, w, a, lat, rd, err, RAM_WAIT + 1, exp_rd);
        end
        n_cmp++;
        if (ra !== RAM_AW'(idx) || rc !== RAM_WAIT || wc !== (w ? RAM_WAIT : 0) || ic !== 0) begin
          n_bad++; $display("FAIL rnd_ram_port: it=%0d ram_addr=%0d en=%0d we=%0d io=%0d want %0d", it, ra, rc, wc, ic, idx);
        end
        last_rd = exp_rd;
      end else if (kind == 1) begin
        a = {4'hF, 26'($urandom), 2'b00};
        k = $urandom_range(1, IO_TO + 4);
        iod = $urandom;
        run_access(w, a, d, k, iod, lat, rd, err, rc, ic, wc, ra, ia);
        if (k <= IO_TO) begin
          exp_lat = k + 1; exp_ic = k; exp_rd = w ? 32'h0 : iod; exp_err = 1'b0;
        end else begin
          exp_lat = IO_TO + 1; exp_ic = IO_TO; exp_rd = ERR_DATA; exp_err = 1'b1;
        end
        n_cmp++;
        if (lat !== exp_lat || rd !== exp_rd || err !== exp_err) begin
          n_bad++; $display("FAIL rnd_io: it=%0d w=%b k=%0d lat=%0d rdata=%h err=%b want %0d/%h/%b", it, w, k, lat, rd, err, exp_lat, exp_rd, exp_err);
        end
        n_cmp++;
        if (ia !== a || ic !== exp_ic || rc !== 0 || wc !== (w ? exp_ic : 0)) begin
          n_bad++; $display("FAIL rnd_io_port: it=%0d io_addr=%h io_cyc=%0d ram=%0d we=%0d want %h/%0d", it, ia, ic, rc, wc, a, exp_ic);
        end
        last_rd = exp_rd;
      end else if (kind == 2) begin
        a = $urandom;
        a[1:0] = 2'($urandom_range(1, 3));
        run_access(w, a, d, 1, 32'h0, lat, rd, err, rc, ic, wc, ra, ia);
        n_cmp++;
        if (lat !== 1 || rd !== ERR_DATA || err !== 1'b1 || rc !== 0 || ic !== 0) begin
          n_bad++; $display("FAIL rnd_misaligned: it=%0d a=%h lat=%0d rdata=%h err=%b ram=%0d io=%0d", it, a, lat, rd, err, rc, ic);
        end
        last_rd = ERR_DATA;
      end else begin
        repeat ($urandom_range(1, 3)) begin
          @(negedge clk);
          n_cmp++;
          if (mio_ready !== 1'b0 || rdata !== last_rd) begin
            n_bad++; $display("FAIL rnd_idle: it=%0d ready=%b rdata=%h want 0/%h", it, mio_ready, rdata, last_rd);
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_ram_rw();
    test_io_read();
    test_io_timeout();
    test_misaligned();
    test_reset_during_io();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, compared=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
